// File: rtl/seq_divider_u8x4_if.sv
// seq_divider_u8x4_if: start/busy/done handshake bus between a requester and the sequential divider
// master drives start/dividend/divisor; slave returns busy, done, quotient, remainder and dbz
interface seq_divider_u8x4_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  dbz;
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, dbz);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, dbz);
endinterface

// File: rtl/seq_divider_u8x4.sv
// seq_divider_u8x4: restoring divider producing one quotient bit per clock behind a start/busy/done handshake
// Ports: clk, rst_n (async, active-low), bus (seq_divider_u8x4_if.slave: start, dividend, divisor in;
// busy, done, quotient, remainder, dbz out). Results hold until the next accepted start.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (quotient truncates toward zero,
// remainder takes the dividend's sign).
module seq_divider_u8x4 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_u8x4_if.slave   bus
);
  localparam int CW = $clog2(DIVIDEND_W + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] wq, q_out, a_mag, q_nx, q_fin;
  logic [DIVISOR_W-1:0]  dvs, r_out, b_mag, r_fin;
  logic [DIVISOR_W:0]    pr, pr_nx;
  logic [DIVISOR_W+1:0]  sh, trial;
  logic                  qneg, rneg, dbz_q, acc, last, dvs_zero, sd, sv, neg;
  always_comb begin
    acc      = bus.start && state != BUSY;
    last     = cnt == CW'(DIVIDEND_W - 1);
    dvs_zero = bus.divisor == '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sd = bus.dividend[DIVIDEND_W-1];
    sv = bus.divisor[DIVISOR_W-1];
`else
    sd = 1'b0;
    sv = 1'b0;
`endif
    a_mag = sd ? -bus.dividend : bus.dividend;
    b_mag = sv ? -bus.divisor : bus.divisor;
    // wq shifts dividend bits out of its MSB and quotient bits into its LSB
    sh    = {pr, wq[DIVIDEND_W-1]};
    trial = sh - {2'b0, dvs};
    neg   = trial[DIVISOR_W+1];
    pr_nx = neg ? sh[DIVISOR_W:0] : trial[DIVISOR_W:0];
    q_nx  = {wq[DIVIDEND_W-2:0], ~neg};
    q_fin = qneg ? -q_nx : q_nx;
    r_fin = rneg ? -pr_nx[DIVISOR_W-1:0] : pr_nx[DIVISOR_W-1:0];
    state_nx = state == BUSY ? (last ? DONE : BUSY) : acc ? (dvs_zero ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      wq    <= '0;
      dvs   <= '0;
      pr    <= '0;
      q_out <= '0;
      r_out <= '0;
      dbz_q <= 1'b0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
    end else if (acc) begin
      wq    <= a_mag;
      dvs   <= b_mag;
      pr    <= '0;
      cnt   <= '0;
      dbz_q <= dvs_zero;
      qneg  <= sd ^ sv;
      rneg  <= sd;
      if (dvs_zero) begin
        q_out <= '1;
        r_out <= bus.dividend[DIVISOR_W-1:0];
      end
    end else if (state == BUSY) begin
      wq  <= q_nx;
      pr  <= pr_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        q_out <= q_fin;
        r_out <= r_fin;
      end
    end
  assign bus.busy      = state == BUSY;
  assign bus.done      = state == DONE;
  assign bus.quotient  = q_out;
  assign bus.remainder = r_out;
  assign bus.dbz       = dbz_q;
endmodule
